// File: rtl/atomik_poly_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : atomik_poly_stream_pkg
//  Brief    : Shared constants, rotation-mode enum and helper functions for
//             the polymorphic XOR stream cipher stage.
//  Revision : 1.0  initial release
// ============================================================================
package atomik_poly_stream_pkg;

   // xorshift32 shift amounts
   localparam int XS_A = 13;
   localparam int XS_B = 17;
   localparam int XS_C = 5;

   // Per-lane decorrelation constant and the substitute for an all-zero seed
   localparam logic [31:0] GOLDEN        = 32'h9E3779B9;
   localparam logic [31:0] ZERO_SEED_SUB = 32'h2545F491;

   typedef enum logic [1:0] {
      MODE_STATIC   = 2'd0,
      MODE_TIMER    = 2'd1,
      MODE_OTP_BEAT = 2'd2,
      MODE_OTP_PKT  = 2'd3
   } mode_e;

   // One xorshift32 step; never maps a non-zero value to zero
   function automatic logic [31:0] xorshift32(input logic [31:0] x);
      logic [31:0] t;
      t = x ^ (x << XS_A);
      t = t ^ (t >> XS_B);
      t = t ^ (t << XS_C);
      return t;
   endfunction

   // xorshift has a fixed point at zero, so a zero seed must never be kept
   function automatic logic [31:0] seed_guard(input logic [31:0] x);
      return (x == 32'd0) ? ZERO_SEED_SUB : x;
   endfunction

   // Rotate left; a shift of 32 yields zero so r == 0 returns x unchanged
   function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] r);
      return (x << r) | (x >> (6'd32 - {1'b0, r}));
   endfunction

endpackage : atomik_poly_stream_pkg
`default_nettype wire

// File: rtl/atomik_poly_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : atomik_poly_stream_if
//  Brief    : Ingress and egress valid/ready stream bundle. The slave modport
//             is the cipher stage; the master modport is its environment
//             (source on the ingress side, sink on the egress side).
//  Revision : 1.0  initial release
// ============================================================================
interface atomik_poly_stream_if #(
   parameter int LANES = 2
);
   // ingress (plaintext)
   logic                  in_valid;
   logic                  in_ready;
   logic [32*LANES-1:0]   in_data;
   logic                  in_last;
   // egress (ciphertext)
   logic                  out_valid;
   logic                  out_ready;
   logic [32*LANES-1:0]   out_data;
   logic                  out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

endinterface : atomik_poly_stream_if
`default_nettype wire

// File: rtl/atomik_poly_stream_keygen.sv
`default_nettype none
// ============================================================================
//  Module   : atomik_poly_stream_keygen
//  Brief    : Holds the seed, rotation timer and epoch counter, decides when
//             the seed rotates and derives one 32-bit key per lane.
//  Revision : 1.0  initial release
// ============================================================================
module atomik_poly_stream_keygen
   import atomik_poly_stream_pkg::*;
#(
   parameter int LANES   = 2,
   parameter int TIMER_W = 32,
   parameter int EPOCH_W = 16
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic [1:0]            cfg_mode_i,
   input  wire logic [TIMER_W-1:0]    cfg_threshold_i,
   input  wire logic [31:0]           cfg_seed_i,
   input  wire logic                  cfg_seed_load_i,
   input  wire logic                  beat_acc_i,
   input  wire logic                  beat_last_i,
   output logic      [32*LANES-1:0]   keys_o,
   output logic      [EPOCH_W-1:0]    epoch_o
);

   logic [31:0]         seed_q,  seed_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [EPOCH_W-1:0]  epoch_q, epoch_d;

   mode_e               w_mode;
   logic                w_timer_en;
   logic                w_timer_hit;
   logic                w_rotate;

   assign w_mode = mode_e'(cfg_mode_i);

   // Rotation decision: the active mode selects exactly one trigger source
   always_comb begin
      w_timer_en  = (w_mode == MODE_TIMER) && (cfg_threshold_i != '0);
      w_timer_hit = w_timer_en && (timer_q == (cfg_threshold_i - TIMER_W'(1)));
      w_rotate    = 1'b0;
      case (w_mode)
         MODE_TIMER:    w_rotate = w_timer_hit;
         MODE_OTP_BEAT: w_rotate = beat_acc_i;
         MODE_OTP_PKT:  w_rotate = beat_acc_i & beat_last_i;
         default:       w_rotate = 1'b0;
      endcase
   end

   // Next state: a seed load overrides any rotation in the same cycle
   always_comb begin
      seed_d  = seed_q;
      timer_d = timer_q;
      epoch_d = epoch_q;
      if (cfg_seed_load_i) begin
         seed_d  = seed_guard(cfg_seed_i);
         timer_d = '0;
         epoch_d = '0;
      end else begin
         // timer only advances in timer mode with a non-zero period, else it holds
         if (w_timer_en) begin
            timer_d = w_timer_hit ? '0 : timer_q + TIMER_W'(1);
         end
         if (w_rotate) begin
            seed_d  = seed_guard(xorshift32(seed_q));
            epoch_d = epoch_q + EPOCH_W'(1);
         end
      end
   end

   // Seed, timer and epoch registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seed_q  <= ZERO_SEED_SUB;
         timer_q <= '0;
         epoch_q <= '0;
      end else begin
         seed_q  <= seed_d;
         timer_q <= timer_d;
         epoch_q <= epoch_d;
      end
   end

   // Lane k key: rotated seed mixed with k*GOLDEN, so lane 0 is the raw seed
   for (genvar k = 0; k < LANES; k++) begin : g_lane_key
      localparam logic [4:0]  c_rot = 5'((7 * k) % 32);
      localparam logic [31:0] c_mix = 32'(k) * GOLDEN;
      assign keys_o[32*k +: 32] = rotl32(seed_q, c_rot) ^ c_mix;
   end

   assign epoch_o = epoch_q;

endmodule : atomik_poly_stream_keygen
`default_nettype wire

// File: rtl/atomik_poly_stream.sv
`default_nettype none
// ============================================================================
//  Module   : atomik_poly_stream
//  Brief    : Multi-lane polymorphic XOR stream cipher stage. One output
//             register (latency 1) with full valid/ready backpressure; the
//             key schedule lives in atomik_poly_stream_keygen.
//  Config   : ATOMIK_POLY_EPOCH_TAG_EN adds out_epoch_o, the epoch used to
//             encrypt the beat currently held in the output register.
//  Revision : 1.0  initial release
// ============================================================================
module atomik_poly_stream
   import atomik_poly_stream_pkg::*;
#(
   parameter int LANES   = 2,
   parameter int TIMER_W = 32,
   parameter int EPOCH_W = 16
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic [1:0]            cfg_mode_i,
   input  wire logic [TIMER_W-1:0]    cfg_threshold_i,
   input  wire logic [31:0]           cfg_seed_i,
   input  wire logic                  cfg_seed_load_i,
   atomik_poly_stream_if.slave        bus,
   output logic      [EPOCH_W-1:0]    epoch_o
`ifdef ATOMIK_POLY_EPOCH_TAG_EN
   ,
   output logic      [EPOCH_W-1:0]    out_epoch_o
`endif
);

   localparam int c_dw = 32 * LANES;

   logic              w_in_ready;
   logic              w_accept;
   logic [c_dw-1:0]   w_keys;
   logic [EPOCH_W-1:0] w_epoch;

   logic              out_valid_q, out_valid_d;
   logic [c_dw-1:0]   out_data_q,  out_data_d;
   logic              out_last_q,  out_last_d;

   // The output register can take a new beat when empty or being drained
   assign w_in_ready = ~out_valid_q | bus.out_ready;
   assign w_accept   = bus.in_valid & w_in_ready;

   atomik_poly_stream_keygen #(
      .LANES   (LANES),
      .TIMER_W (TIMER_W),
      .EPOCH_W (EPOCH_W)
   ) u_keygen (
      .clk             (clk),
      .rst             (rst),
      .cfg_mode_i      (cfg_mode_i),
      .cfg_threshold_i (cfg_threshold_i),
      .cfg_seed_i      (cfg_seed_i),
      .cfg_seed_load_i (cfg_seed_load_i),
      .beat_acc_i      (w_accept),
      .beat_last_i     (bus.in_last),
      .keys_o          (w_keys),
      .epoch_o         (w_epoch)
   );

   // Output register next state: load on accept, drop valid once drained, else hold
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (w_accept) begin
         out_valid_d = 1'b1;
         out_data_d  = bus.in_data ^ w_keys;
         out_last_d  = bus.in_last;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register; reset drops any in-flight beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

`ifdef ATOMIK_POLY_EPOCH_TAG_EN
   logic [EPOCH_W-1:0] out_epoch_q;

   // Epoch tag travels with the beat so a decryptor can resynchronise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_epoch_q <= '0;
      end else if (w_accept) begin
         out_epoch_q <= w_epoch;
      end
   end

   assign out_epoch_o = out_epoch_q;
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign epoch_o       = w_epoch;

endmodule : atomik_poly_stream
`default_nettype wire

// File: tb/tb_atomik_poly_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_atomik_poly_stream
//  Brief    : Self-checking bench for atomik_poly_stream (LANES=2) with a
//             behavioural reference model and directed vectors.
//  Config   : honours ATOMIK_POLY_EPOCH_TAG_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_atomik_poly_stream;
   import atomik_poly_stream_pkg::*;

   localparam int LANES   = 2;
   localparam int TIMER_W = 32;
   localparam int EPOCH_W = 16;
   localparam int DW      = 32 * LANES;

   logic                clk = 1'b0;
   logic                rst;
   logic [1:0]          cfg_mode;
   logic [TIMER_W-1:0]  cfg_threshold;
   logic [31:0]         cfg_seed;
   logic                cfg_seed_load;
   logic [EPOCH_W-1:0]  epoch;
`ifdef ATOMIK_POLY_EPOCH_TAG_EN
   logic [EPOCH_W-1:0]  out_epoch;
`endif

   int n_vec = 0;
   int n_bad = 0;
   bit run_cmp = 1'b0;

   always #5 clk = ~clk;

   atomik_poly_stream_if #(.LANES(LANES)) bus ();

   atomik_poly_stream #(
      .LANES   (LANES),
      .TIMER_W (TIMER_W),
      .EPOCH_W (EPOCH_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_mode_i      (cfg_mode),
      .cfg_threshold_i (cfg_threshold),
      .cfg_seed_i      (cfg_seed),
      .cfg_seed_load_i (cfg_seed_load),
      .bus             (bus.slave),
      .epoch_o         (epoch)
`ifdef ATOMIK_POLY_EPOCH_TAG_EN
      ,
      .out_epoch_o     (out_epoch)
`endif
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_xs(input logic [31:0] s);
      logic [31:0] x;
      x = s;
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      return (x == 0) ? 32'h2545F491 : x;
   endfunction

   function automatic logic [DW-1:0] m_keys(input logic [31:0] s);
      logic [DW-1:0] r;
      logic [63:0]   dbl;
      logic [31:0]   kk;
      r = '0;
      for (int k = 0; k < LANES; k++) begin
         dbl = {s, s} << ((7 * k) % 32);
         kk  = k;
         r[32*k +: 32] = dbl[63:32] ^ (kk * 32'h9E3779B9);
      end
      return r;
   endfunction

   logic [31:0]         m_seed;
   logic [TIMER_W-1:0]  m_timer;
   logic [EPOCH_W-1:0]  m_epoch, m_tag;
   logic                m_valid, m_last;
   logic [DW-1:0]       m_data;
   logic                m_acc, m_rot;

   assign m_acc = bus.in_valid && (!m_valid || bus.out_ready);
   assign m_rot = (cfg_mode == 2'd1 && cfg_threshold != 0 && m_timer == cfg_threshold - 1) ||
                  (cfg_mode == 2'd2 && m_acc) ||
                  (cfg_mode == 2'd3 && m_acc && bus.in_last);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_seed  <= 32'h2545F491;
         m_timer <= '0;
         m_epoch <= '0;
         m_tag   <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         m_data  <= '0;
      end else begin
         if (m_acc) begin
            m_data  <= bus.in_data ^ m_keys(m_seed);
            m_last  <= bus.in_last;
            m_valid <= 1'b1;
            m_tag   <= m_epoch;
         end else if (bus.out_ready) begin
            m_valid <= 1'b0;
         end
         if (cfg_seed_load) begin
            m_seed  <= (cfg_seed == 0) ? 32'h2545F491 : cfg_seed;
            m_timer <= '0;
            m_epoch <= '0;
         end else begin
            if (cfg_mode == 2'd1 && cfg_threshold != 0)
               m_timer <= (m_timer == cfg_threshold - 1) ? '0 : m_timer + 1;
            if (m_rot) begin
               m_seed  <= m_xs(m_seed);
               m_epoch <= m_epoch + 1'b1;
            end
         end
      end
   end

   // Compare process: every cycle outside reset
   always @(negedge clk) begin
      if (run_cmp && !rst) begin
         chk("mdl_out_valid", DW'(bus.out_valid), DW'(m_valid));
         chk("mdl_in_ready", DW'(bus.in_ready), DW'(!m_valid || bus.out_ready));
         chk("mdl_epoch", DW'(epoch), DW'(m_epoch));
         if (m_valid) begin
            chk("mdl_out_data", bus.out_data, m_data);
            chk("mdl_out_last", DW'(bus.out_last), DW'(m_last));
`ifdef ATOMIK_POLY_EPOCH_TAG_EN
            chk("mdl_out_epoch", DW'(out_epoch), DW'(m_tag));
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] s);
      cfg_seed      = s;
      cfg_seed_load = 1'b1;
      tick();
      cfg_seed_load = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] hold_exp;
      rst           = 1'b1;
      cfg_mode      = 2'd0;
      cfg_threshold = '0;
      cfg_seed      = '0;
      cfg_seed_load = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", DW'(bus.out_valid), '0);
      chk("rst_out_data", bus.out_data, '0);
      chk("rst_out_last", DW'(bus.out_last), '0);
      chk("rst_epoch", DW'(epoch), '0);
      rst     = 1'b0;
      run_cmp = 1'b1;

      // reset seed is the zero-seed substitute
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("rst_seed_lane0", DW'(bus.out_data[31:0]), DW'(32'h2545F491));

      // 1: static mode, seed 1
      load(32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = '0;
      tick();
      bus.in_valid = 1'b0;
      chk("t1_valid_lat1", DW'(bus.out_valid), DW'(1));
      chk("t1_data", bus.out_data, 64'h9E377939_00000001);
      tick();
      chk("t1_drained", DW'(bus.out_valid), '0);

      // 2: OTP per beat, then seed load colliding with an accepted beat
      cfg_mode = 2'd2;
      load(32'd1);
      bus.in_valid = 1'b1;
      tick();
      chk("t2_beat0", DW'(bus.out_data[31:0]), DW'(32'h00000001));
      tick();
      bus.in_valid = 1'b0;
      chk("t2_beat1", DW'(bus.out_data[31:0]), DW'(32'h00042021));
      chk("t2_epoch", DW'(epoch), DW'(2));
      cfg_seed      = 32'd9;
      cfg_seed_load = 1'b1;
      bus.in_valid  = 1'b1;
      tick();
      cfg_seed_load = 1'b0;
      bus.in_valid  = 1'b0;
      chk("t2_load_old_seed", DW'(bus.out_data[31:0]), DW'(32'h04080601));
      chk("t2_load_epoch0", DW'(epoch), '0);
      tick();

      // 3: timer mode, period 3
      cfg_mode      = 2'd1;
      cfg_threshold = 32'd3;
      load(32'd1);
      repeat (9) tick();
      chk("t3_epoch", DW'(epoch), DW'(3));
      cfg_threshold = '0;
      repeat (4) tick();
      chk("t3_thr0_hold", DW'(epoch), DW'(3));

      // 4: backpressure in OTP-beat mode
      cfg_mode = 2'd2;
      load(32'd5);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 64'h11112222_33334444;
      hold_exp      = 64'h11112222_33334444 ^ m_keys(32'd5);
      tick();
      for (int i = 0; i < 5; i++) begin
         bus.in_data = 64'hA5A5A5A5_00000000 + 64'(i);
         tick();
         chk("t4_in_ready", DW'(bus.in_ready), '0);
         chk("t4_data_stable", bus.out_data, hold_exp);
         chk("t4_epoch", DW'(epoch), DW'(1));
      end
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("t4_release_epoch", DW'(epoch), DW'(2));
      tick();

      // 5: OTP per packet, 4-beat packet
      cfg_mode = 2'd3;
      load(32'd7);
      bus.in_data = '0;
      for (int b = 0; b < 4; b++) begin
         bus.in_valid = 1'b1;
         bus.in_last  = (b == 3);
         tick();
         chk("t5_lane0_key", DW'(bus.out_data[31:0]), DW'(32'd7));
         chk("t5_epoch", DW'(epoch), DW'((b == 3) ? 1 : 0));
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      tick();

      // 6: zero seed guard, then reset mid-burst
      cfg_mode = 2'd0;
      load(32'd0);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("t6_zero_seed", DW'(bus.out_data[31:0]), DW'(32'h2545F491));
      cfg_mode     = 2'd2;
      bus.in_valid = 1'b1;
      bus.in_data  = 64'h0123456789ABCDEF;
      repeat (3) tick();
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", DW'(bus.out_valid), '0);
      chk("t6_rst_data", bus.out_data, '0);
      chk("t6_rst_epoch", DW'(epoch), '0);
      bus.in_valid = 1'b0;
      tick();
      rst = 1'b0;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_atomik_poly_stream
`default_nettype wire
